// File: rtl/modbus_tx_sequencer.sv
// modbus_tx_sequencer: Modbus RTU response transmitter with on-the-fly CRC-16 and RS-485 DE guard timing.
// Optional TX_CRC_APPEND_EN appends the computed CRC; otherwise the buffer is sent verbatim.
module modbus_tx_sequencer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int GUARD_BITS = 1,
  parameter int BUF_AW     = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start,
  input  logic [7:0]        frame_len,
  output logic              busy,
  output logic              frame_done,
  output logic [BUF_AW-1:0] buf_addr,
  input  logic [7:0]        buf_rdata,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              rs485_de,
  output logic [15:0]       crc_out
);
  localparam int GUARD = GUARD_BITS * (CLK_FREQ / BAUD_RATE);
  localparam int CW = $clog2(GUARD + 1);
  typedef enum logic [3:0] {
    IDLE, LEAD, FETCH, RDWAIT, WAIT_DONE, LAG
`ifdef TX_CRC_APPEND_EN
    , CRC_LO, WAIT_LO, CRC_HI, WAIT_HI
`endif
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] idx_q, idx_d, len_q, len_d, data_q, data_d;
  logic [15:0] crc_q, crc_d, crc_out_q, crc_out_d;
  logic [BUF_AW-1:0] addr_q, addr_d;
  logic start_q, start_d, done_q, done_d, busy_q, busy_d, de_q, de_d;
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      crc_q     <= 16'hFFFF;
      crc_out_q <= '0;
      addr_q    <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      de_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      data_q    <= data_d;
      crc_q     <= crc_d;
      crc_out_q <= crc_out_d;
      addr_q    <= addr_d;
      start_q   <= start_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      de_q      <= de_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    len_d     = len_q;
    data_d    = data_q;
    crc_d     = crc_q;
    crc_out_d = crc_out_q;
    addr_d    = addr_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    de_d      = de_q;
    case (state_q)
      IDLE: if (frame_start && frame_len != 8'd0) begin
        state_d = LEAD;
        len_d   = frame_len;
        idx_d   = '0;
        crc_d   = 16'hFFFF;
        cnt_d   = '0;
        busy_d  = 1'b1;
        de_d    = 1'b1;
      end
      LEAD: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(GUARD - 1)) begin
          cnt_d   = '0;
          state_d = FETCH;
          addr_d  = BUF_AW'(idx_q);
        end
      end
      FETCH: state_d = RDWAIT;
      RDWAIT: begin
        data_d  = buf_rdata;
        start_d = 1'b1;
        crc_d   = crc_upd(crc_q, buf_rdata);
        state_d = WAIT_DONE;
      end
      WAIT_DONE: if (tx_done) begin
        idx_d = idx_q + 8'd1;
        if ({1'b0, idx_q} + 9'd1 < {1'b0, len_q}) begin
          state_d = FETCH;
          addr_d  = BUF_AW'(idx_q + 8'd1);
        end else begin
`ifdef TX_CRC_APPEND_EN
          state_d = CRC_LO;
`else
          state_d   = LAG;
          crc_out_d = crc_q;
`endif
        end
      end
`ifdef TX_CRC_APPEND_EN
      CRC_LO: begin
        data_d  = crc_q[7:0];
        start_d = 1'b1;
        state_d = WAIT_LO;
      end
      WAIT_LO: state_d = tx_done ? CRC_HI : WAIT_LO;
      CRC_HI: begin
        data_d  = crc_q[15:8];
        start_d = 1'b1;
        state_d = WAIT_HI;
      end
      WAIT_HI: if (tx_done) begin
        state_d   = LAG;
        crc_out_d = crc_q;
      end
`endif
      LAG: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(GUARD - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          de_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign buf_addr   = addr_q;
  assign tx_start   = start_q;
  assign tx_data    = data_q;
  assign rs485_de   = de_q;
  assign crc_out    = crc_out_q;
endmodule

// File: tb/tb_modbus_tx_sequencer.sv
// tb_modbus_tx_sequencer: directed bench with a registered buffer model and a fixed-latency UART stand-in.
module tb_modbus_tx_sequencer;
  localparam int G = 434;
`ifdef TX_CRC_APPEND_EN
  localparam int PL = 6;
  localparam int XB = 2;
  localparam logic [15:0] CA = 16'hCAD5;
  localparam logic [15:0] CB = 16'h0B98;
`else
  localparam int PL = 8;
  localparam int XB = 0;
  localparam logic [15:0] CA = 16'h0000;
  localparam logic [15:0] CB = 16'h0000;
`endif
  localparam int NB = PL + XB;
  logic clk_in = 1'b0, rst_in = 1'b1, frame_start = 1'b0, tx_done;
  logic [7:0] frame_len = 8'd0, buf_rdata, buf_addr, tx_data;
  logic busy, frame_done, tx_start, rs485_de;
  logic [15:0] crc_out;
  logic u_done = 1'b0, s_done = 1'b0, prev_start = 1'b0;
  logic [7:0] mem [0:255];
  logic [7:0] cap [0:255];
  int nstart = 0, ndone = 0, consec = 0, cd = 0, maxaddr = 0;
  int total = 0, bad = 0;
  assign tx_done = u_done | s_done;
  always #5 clk_in = ~clk_in;

  modbus_tx_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start), .frame_len(frame_len),
    .busy(busy), .frame_done(frame_done), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .rs485_de(rs485_de),
    .crc_out(crc_out)
  );

  always @(posedge clk_in) buf_rdata <= mem[buf_addr];

  // UART stand-in: records each launched byte and answers tx_done 20 cycles later
  always @(negedge clk_in) begin
    u_done     <= 1'b0;
    prev_start <= tx_start;
    if (tx_start) begin
      cap[nstart & 255] <= tx_data;
      nstart <= nstart + 1;
      cd <= 20;
      if (prev_start) consec <= consec + 1;
    end else if (cd == 1) begin
      u_done <= 1'b1;
      cd <= 0;
    end else if (cd > 1) cd <= cd - 1;
    if (frame_done) ndone <= ndone + 1;
    if (int'(buf_addr) > maxaddr) maxaddr <= int'(buf_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [63:0] v);
    for (int i = 0; i < 8; i++) mem[i] = v[63-8*i -: 8];
  endtask

  task automatic run_frame(input string tag, input int len, input int nb, input int pulse_at,
                           input bit spur, input logic [15:0] ecrc);
    int k = 0, first = -1, lag = 0, s0 = nstart, d0 = ndone;
    bit fin = 1'b0;
    logic [7:0] eb;
    frame_start = 1'b1;
    frame_len = len[7:0];
    while (!fin && k < 20000) begin
      @(negedge clk_in);
      k++;
      if (k == 1) begin
        chk({tag, " busy_up"}, busy, 1);
        chk({tag, " de_up"}, rs485_de, 1);
      end
      if (tx_start && first < 0) first = k;
      if (u_done) lag = rs485_de ? 1 : 0;
      else if (rs485_de) lag++;
      if (frame_done) begin
        fin = 1'b1;
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " de_at_done"}, rs485_de, 0);
      end
      frame_start = (k == pulse_at);
      if (k == pulse_at) frame_len = 8'd3;
      s_done = spur && (k == 100 || (lag == 50 && nstart - s0 == nb));
    end
    s_done = 1'b0;
    frame_start = 1'b0;
    chk({tag, " finished"}, fin, 1);
    chk({tag, " first_start"}, first, G + 3);
    chk({tag, " de_lag"}, lag, G);
    chk({tag, " nbytes"}, nstart - s0, nb);
    if (nb <= 8) begin
      for (int i = 0; i < nb; i++) begin
        eb = (i < len) ? mem[i] : (i == len ? ecrc[7:0] : ecrc[15:8]);
        chk($sformatf("%s byte%0d", tag, i), cap[(s0 + i) & 255], eb);
      end
      chk({tag, " crc_out"}, crc_out, ecrc);
    end
    @(negedge clk_in);
    chk({tag, " done_pulse_width"}, frame_done, 0);
    chk({tag, " done_count"}, ndone - d0, 1);
  endtask

  initial begin
    int s0, d0, k;
    repeat (3) @(negedge clk_in);
    chk("rst busy", busy, 0);
    chk("rst de", rs485_de, 0);
    chk("rst tx_start", tx_start, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst crc_out", crc_out, 0);
    chk("rst buf_addr", buf_addr, 0);
    chk("rst tx_data", tx_data, 0);
    rst_in = 1'b0;
    @(negedge clk_in);
    load(64'h01030001_0001D5CA);
    run_frame("s1", PL, NB, 0, 1'b0, CA);
    load(64'h01060001_0003980B);
    run_frame("s2", PL, NB, 0, 1'b0, CB);
    load(64'h01030001_0001D5CA);
    run_frame("s3_midstart", PL, NB, 600, 1'b0, CA);
    s0 = nstart;
    frame_start = 1'b1;
    frame_len = 8'd0;
    @(negedge clk_in);
    frame_start = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("s3_len0 busy", busy, 0);
    chk("s3_len0 de", rs485_de, 0);
    chk("s3_len0 bytes", nstart - s0, 0);
    s0 = nstart;
    k = 0;
    frame_start = 1'b1;
    frame_len = PL[7:0];
    @(negedge clk_in);
    frame_start = 1'b0;
    while (nstart - s0 < 4 && k < 5000) begin
      @(negedge clk_in);
      k++;
    end
    chk("s4 reached_byte4", nstart - s0, 4);
    repeat (5) @(negedge clk_in);
    rst_in = 1'b1;
    d0 = ndone;
    @(negedge clk_in);
    chk("s4 de_after_rst", rs485_de, 0);
    chk("s4 busy_after_rst", busy, 0);
    chk("s4 start_after_rst", tx_start, 0);
    rst_in = 1'b0;
    repeat (600) @(negedge clk_in);
    chk("s4 no_frame_done", ndone - d0, 0);
    chk("s4 no_more_bytes", nstart - s0, 4);
    run_frame("s4_after", PL, NB, 0, 1'b0, CA);
    s_done = 1'b1;
    @(negedge clk_in);
    s_done = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("s6 idle_spur busy", busy, 0);
    run_frame("s6_spur", PL, NB, 0, 1'b1, CA);
    for (int i = 0; i < 256; i++) mem[i] = i[7:0];
    run_frame("s255", 255, 255 + XB, 0, 1'b0, 16'h0000);
    chk("s255 max_addr", maxaddr, 254);
    chk("no_back_to_back_start", consec, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
